// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded instruction requests into 32-bit MIPS words
// and writes them to consecutive imem addresses through a two-state write FSM.
module instr_encoder #(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err,
  output logic          done
);

  typedef enum logic [2:0] {
    KIND_RTYPE = 3'd0,
    KIND_LW    = 3'd1,
    KIND_SW    = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_ADDI  = 3'd4,
    KIND_J     = 3'd5
  } kind_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_ADDI  = 6'b001000;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C    = (AW+1)'(1);

  state_e      state_q, state_d;
  logic [31:0] word_q,  word_d;
  logic        last_q,  last_d;
  logic [AW:0] count_q, count_d;
  logic        err_q,   err_d;
  logic        done_q,  done_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        full_w;
  logic        abort;
  logic        accept;

  // Word packing; fields a kind does not use never reach the word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_kind)
      KIND_RTYPE: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, in_funct};
      KIND_LW:    enc_word = {OP_LW,    in_rs, in_rt, in_imm};
      KIND_SW:    enc_word = {OP_SW,    in_rs, in_rt, in_imm};
      KIND_BEQ:   enc_word = {OP_BEQ,   in_rs, in_rt, in_imm};
      KIND_ADDI:  enc_word = {OP_ADDI,  in_rs, in_rt, in_imm};
      KIND_J:     enc_word = {OP_J,     in_target};
      default:    enc_legal = 1'b0;
    endcase
  end

  assign abort    = reset | clear;
  assign full_w   = (count_q == DEPTH_C);
  assign in_ready = (state_q == S_IDLE) & ~full_w & ~done_q & ~abort;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = done_q;
    if (clear) begin
      state_d = S_IDLE;
      word_d  = '0;
      last_d  = 1'b0;
      count_d = '0;
      err_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            last_d = in_last;
            if (enc_legal) begin
              word_d  = enc_word;
              state_d = S_WRITE;
            end else begin
              // Illegal requests are consumed without a write; last still ends the program.
              err_d  = 1'b1;
              done_d = done_q | in_last;
            end
          end
        end
        S_WRITE: begin
          count_d = count_q + ONE_C;
          done_d  = done_q | last_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // A reset or clear seen during WRITE suppresses the strobe on that same edge.
  assign imem_we   = (state_q == S_WRITE) & ~abort;
  assign imem_addr = count_q[AW-1:0];
  assign imem_wd   = word_q;
  assign count     = count_q;
  assign full      = full_w;
  assign err       = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: transaction-level model checked every
// cycle, plus hand-computed encodings and timing pins for the directed tests.
module tb_instr_encoder;

  localparam int AW    = 6;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } req_t;

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_ready, in_last;
  logic [2:0]    in_kind;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          imem_we, full, err, done;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic [AW:0]   count;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .count(count), .full(full), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: instruction words straight from the encoding table.
  function automatic logic [31:0] encode(input req_t r);
    case (r.kind)
      3'd0:    return {6'b000000, r.rs, r.rt, r.rd, 5'd0, r.funct};
      3'd1:    return {6'b100011, r.rs, r.rt, r.imm};
      3'd2:    return {6'b101011, r.rs, r.rt, r.imm};
      3'd3:    return {6'b000100, r.rs, r.rt, r.imm};
      3'd4:    return {6'b001000, r.rs, r.rt, r.imm};
      3'd5:    return {6'b000010, r.target};
      default: return 32'd0;
    endcase
  endfunction

  function automatic req_t mk(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                              input logic [25:0] target, input logic last);
    req_t r;
    r.kind = kind; r.rs = rs; r.rt = rt; r.rd = rd; r.funct = funct;
    r.imm = imm; r.target = target; r.last = last;
    return r;
  endfunction

  // Model state: a word waiting to be written, words written, sticky flags.
  bit          m_pend, m_pend_last, m_err, m_done;
  int          m_count;
  logic [31:0] m_wd;
  logic [31:0] m_mem [DEPTH];

  function automatic bit m_ready();
    return !m_pend && (m_count != DEPTH) && !m_done && !clear && !reset;
  endfunction

  always @(posedge clk) begin
    req_t cur;
    cur = mk(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last);
    if (reset || clear) begin
      m_pend = 0; m_pend_last = 0; m_err = 0; m_done = 0; m_count = 0; m_wd = '0;
    end else if (m_pend) begin
      if (m_count < DEPTH) m_mem[m_count] = m_wd;
      m_count++;
      m_done = m_done | m_pend_last;
      m_pend = 0;
    end else if (in_valid && m_ready()) begin
      if (in_kind <= 3'd5) begin
        m_pend = 1; m_wd = encode(cur); m_pend_last = in_last;
      end else begin
        m_err = 1;
        if (in_last) m_done = 1;
      end
    end
  end

  // Observed DUT behaviour, sampled mid-cycle.
  logic [31:0] dut_mem [DEPTH];
  int          dut_writes = 0;
  int          cyc = 0;
  int          last_hs_cyc = -1;
  int          last_we_cyc = -1;

  always @(negedge clk) begin
    bit exp_we;
    cyc++;
    exp_we = m_pend && !reset && !clear;
    if (!reset && !clear) check("in_ready", 32'(in_ready), 32'(m_ready()));
    check("imem_we", 32'(imem_we), 32'(exp_we));
    if (exp_we) check("imem_addr", 32'(imem_addr), 32'(m_count));
    check("imem_wd", imem_wd, m_wd);
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("err", 32'(err), 32'(m_err));
    check("done", 32'(done), 32'(m_done));
    if (imem_we === 1'b1) begin
      if (imem_addr < DEPTH) dut_mem[imem_addr] = imem_wd;
      dut_writes++;
      last_we_cyc = cyc;
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) last_hs_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input req_t r);
    in_kind = r.kind; in_rs = r.rs; in_rt = r.rt; in_rd = r.rd;
    in_funct = r.funct; in_imm = r.imm; in_target = r.target; in_last = r.last;
  endtask

  task automatic send(input req_t r, input int max_cycles, output bit accepted);
    apply(r);
    in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        accepted = 1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_ok(input req_t r);
    bit acc;
    send(r, 8, acc);
    check("handshake_within_bound", 32'(acc), 32'd1);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < DEPTH; i++) begin
      dut_mem[i] = '0;
      m_mem[i]   = '0;
    end
    dut_writes = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    clear_logs();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    req_t v [5];
    bit   acc;
    int   hs_cycles [$];
    int   idx;
    bit   hs;

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    apply(mk(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0));
    clear_logs();
    tick();
    tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_wd", imem_wd, 32'd0);
    check("reset_flags", {29'd0, full, err, done}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: single ADDI, write one cycle after the handshake.
    send_ok(mk(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0));
    tick();
    check("t1_word", dut_mem[0], 32'h2002_0005);
    check("t1_writes", 32'(dut_writes), 32'd1);
    check("t1_latency", 32'(last_we_cyc - last_hs_cyc), 32'd1);
    check("t1_count", 32'(count), 32'd1);

    // 2: four-instruction program ending with J marked last.
    do_clear();
    send_ok(mk(3'd0, 5'd2, 5'd3, 5'd4, 6'h20, 16'd0, 26'd0, 1'b0));
    send_ok(mk(3'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0050, 26'd0, 1'b0));
    send_ok(mk(3'd2, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0054, 26'd0, 1'b0));
    send_ok(mk(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h11, 1'b1));
    tick();
    tick();
    check("t2_w0", dut_mem[0], 32'h0043_2020);
    check("t2_w1", dut_mem[1], 32'h8C02_0050);
    check("t2_w2", dut_mem[2], 32'hAC02_0054);
    check("t2_w3", dut_mem[3], 32'h0800_0011);
    check("t2_done", 32'(done), 32'd1);
    check("t2_ready", 32'(in_ready), 32'd0);

    // 3: illegal kind sets err, writes nothing, does not block the next request.
    do_clear();
    send_ok(mk(3'd7, 5'd1, 5'd2, 5'd3, 6'h3F, 16'h1234, 26'h155, 1'b0));
    tick();
    check("t3_err", 32'(err), 32'd1);
    check("t3_no_write", 32'(dut_writes), 32'd0);
    check("t3_count", 32'(count), 32'd0);
    send_ok(mk(3'd4, 5'd1, 5'd3, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0));
    tick();
    check("t3_legal_word", dut_mem[0], 32'h2023_FFFF);
    check("t3_err_sticky", 32'(err), 32'd1);
    send_ok(mk(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1));
    tick();
    check("t3_illegal_last_done", 32'(done), 32'd1);
    check("t3_count_after", 32'(count), 32'd1);

    // 4: five requests into a four-word memory.
    do_clear();
    for (int i = 0; i < 4; i++)
      send_ok(mk(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE - 16'(i), 26'd0, 1'b0));
    send(mk(3'd4, 5'd9, 5'd9, 5'd0, 6'd0, 16'h0BAD, 26'd0, 1'b0), 6, acc);
    check("t4_fifth_rejected", 32'(acc), 32'd0);
    check("t4_full", 32'(full), 32'd1);
    check("t4_count", 32'(count), 32'd4);
    check("t4_writes", 32'(dut_writes), 32'd4);
    check("t4_w0", dut_mem[0], 32'h1022_FFFE);
    for (int i = 0; i < DEPTH; i++) check("t4_mem_vs_model", dut_mem[i], m_mem[i]);

    // 6: in_valid held; handshakes land on every second edge.
    do_clear();
    v[0] = mk(3'd0, 5'd5, 5'd6, 5'd7, 6'h22, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
    v[1] = mk(3'd2, 5'd29, 5'd31, 5'd0, 6'd0, 16'h8000, 26'd0, 1'b0);
    v[2] = mk(3'd5, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
    v[3] = mk(3'd4, 5'd31, 5'd31, 5'd0, 6'd0, 16'h7FFF, 26'd0, 1'b0);
    v[4] = mk(3'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
    idx = 0;
    apply(v[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      hs = (in_ready === 1'b1);
      tick();
      if (hs) begin
        hs_cycles.push_back(c);
        idx++;
        if (idx < 5) apply(v[idx]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("t6_handshakes", 32'(hs_cycles.size()), 32'd4);
    for (int i = 1; i < hs_cycles.size(); i++)
      check("t6_spacing", 32'(hs_cycles[i] - hs_cycles[i-1]), 32'd2);
    check("t6_writes", 32'(dut_writes), 32'd4);
    check("t6_rtype_word", dut_mem[0], 32'h00A6_3822);
    check("t6_j_word", dut_mem[2], 32'h0BFF_FFFF);
    for (int i = 0; i < DEPTH; i++) check("t6_mem_vs_model", dut_mem[i], encode(v[i]));

    // Clear during the WRITE cycle aborts the write.
    do_clear();
    send_ok(mk(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0));
    clear = 1'b1;
    @(negedge clk);
    check("clr_no_we", 32'(imem_we), 32'd0);
    tick();
    clear = 1'b0;
    tick();
    check("clr_writes", 32'(dut_writes), 32'd0);
    check("clr_count", 32'(count), 32'd0);

    // 5: reset during the WRITE cycle aborts the write and restores reset values.
    send_ok(mk(3'd1, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b1));
    reset = 1'b1;
    @(negedge clk);
    check("rst_no_we", 32'(imem_we), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_writes", 32'(dut_writes), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_wd", imem_wd, 32'd0);
    check("rst_flags", {29'd0, full, err, done}, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
